// File: rtl/tt_seg7_reader.sv
// tt_seg7_reader
//   Reads a 7-segment pattern arriving on input pins, waits until it has
//   been stable for STABLE_CYCLES synchronized samples, decodes it to a hex
//   digit and queues the result in a first-word fall-through FIFO that is
//   drained over a valid/ready handshake.
//
//   Optional feature macro: SEG7_READER_DP_EN
//     defined   - dp_in port exists, dp joins the stability comparison and
//                 is stored per entry and driven on out_dp.
//     undefined - no dp_in port, out_dp is constant 0.
//
// Parameters
//   STABLE_CYCLES : identical synchronized samples needed to commit (1..255)
//   FIFO_DEPTH    : digit queue entries, power of 2 (2..16)
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   commit enable (popping works regardless)
//   seg_in     in   segments a..g, bit0 = a
//   dp_in      in   decimal point (macro only)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer accepts head entry
//   out_digit  out  head digit
//   out_err    out  head came from an undecodable pattern
//   out_dp     out  head decimal point
//   overflow   out  sticky: a commit was dropped on a full FIFO
//   level      out  FIFO occupancy
module tt_seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [6:0] seg_in,
`ifdef SEG7_READER_DP_EN
    input  logic       dp_in,
`endif
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       out_dp,
    output logic       overflow,
    output logic [4:0] level
);

`ifdef SEG7_READER_DP_EN
    localparam int SW = 8;   // {dp, seg}
    localparam int EW = 6;   // {dp, err, digit}
`else
    localparam int SW = 7;   // seg
    localparam int EW = 5;   // {err, digit}
`endif
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [4:0] LVL_MAX = 5'(FIFO_DEPTH);

    // Returns {err, digit}; unknown patterns decode to digit 0 with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [SW-1:0] raw_in;
`ifdef SEG7_READER_DP_EN
    assign raw_in = {dp_in, seg_in};
`else
    assign raw_in = seg_in;
`endif

    logic [SW-1:0] sync1_q, sync1_d;
    logic [SW-1:0] sync2_q, sync2_d;
    logic [SW-1:0] cand_q, cand_d;
    logic [SW-1:0] last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [4:0]    level_q, level_d;
    logic          overflow_q, overflow_d;

    logic          reach, commit, push_req, push, pop, full, empty;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    always_comb begin
        // Synchronizer stage
        sync1_d = raw_in;
        sync2_d = sync1_q;

        // Stability tracker stage. reach marks the edge on which cnt
        // arrives at CNT_MAX (not the cycles it merely sits saturated).
        cand_d = cand_q;
        cnt_d  = cnt_q;
        reach  = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = ena ? 8'd1 : 8'd0;
            reach  = ena && (CNT_MAX == 8'd1);
        end else if (!ena) begin
            cnt_d = 8'd0;
        end else begin
            reach = (cnt_q == CNT_MAX - 8'd1);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // Commit stage. A blank commit only refreshes last so that a digit
        // repeated after a blank is captured again.
        commit   = reach && (cand_d != last_q);
        last_d   = commit ? cand_d : last_q;
        push_req = commit && (cand_d[6:0] != 7'h00);
`ifdef SEG7_READER_DP_EN
        entry    = {cand_d[7], seg_decode(cand_d[6:0])};
`else
        entry    = seg_decode(cand_d[6:0]);
`endif

        // FIFO control stage. A push into a full FIFO survives only when a
        // pop frees the head slot on the same edge.
        full       = (level_q == LVL_MAX);
        empty      = (level_q == 5'd0);
        pop        = !empty && out_ready;
        push       = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req && full && !pop);
        wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            last_q     <= '0;
            cnt_q      <= 8'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage holds data only; validity comes from level, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= entry;
        end
    end

    // Output stage: head fields are masked while empty so outputs read 0.
    assign head      = mem_q[rptr_q];
    assign out_valid = !empty;
    assign out_digit = empty ? 4'h0 : head[3:0];
    assign out_err   = !empty && head[4];
`ifdef SEG7_READER_DP_EN
    assign out_dp    = !empty && head[5];
`else
    assign out_dp    = 1'b0;
`endif
    assign overflow  = overflow_q;
    assign level     = level_q;

endmodule

// File: tb/tb_tt_seg7_reader.sv
// Testbench for tt_seg7_reader (default parameters). Stimulus pushes each
// expected {err, digit} into a scoreboard queue; a monitor pops and compares
// on every accepted handshake. Status outputs are checked directly.
module tb_tt_seg7_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [6:0] seg_in;
    logic       dp_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_err;
    logic       out_dp;
    logic       overflow;
    logic [4:0] level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb [$];

    tt_seg7_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .seg_in    (seg_in),
`ifdef SEG7_READER_DP_EN
        .dp_in     (dp_in),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_err   (out_err),
        .out_dp    (out_dp),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        seg_in = pat;
        tick(n);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick(1);
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);
    endtask

    // Monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got digit %0d err %0d, expected nothing queued",
                         out_digit, out_err);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                check("pop_digit", out_digit, e[3:0]);
                check("pop_err", out_err, e[4]);
                check("pop_dp", out_dp, 0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        seg_in    = 7'h06;
        dp_in     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_digit", out_digit, 0);
        check("rst_err", out_err, 0);
        check("rst_dp", out_dp, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", level, 0);

        // First commit latency: valid after edge 6 following release
        rst_n = 1'b1;
        sb.push_back(5'h01);
        tick(5);
        check("lat_valid_e5", out_valid, 0);
        tick(1);
        check("lat_valid_e6", out_valid, 1);
        check("lat_digit", out_digit, 1);
        check("lat_err", out_err, 0);
        check("lat_level", level, 1);
        drain();

        // Glitch of 3 cycles, then stable 3
        hold(7'h5B, 3);
        sb.push_back(5'h03);
        hold(7'h4F, 10);
        check("glitch_level", level, 1);
        hold(7'h4F, 10);
        check("repeat_level", level, 1);
        hold(7'h00, 6);
        check("blank_level", level, 1);
        sb.push_back(5'h03);
        hold(7'h4F, 10);
        check("reblank_level", level, 2);
        drain();

        // Undecodable pattern
        sb.push_back(5'h10);
        hold(7'h7E, 12);
        check("inv_level", level, 1);
        check("inv_err", out_err, 1);
        check("inv_digit", out_digit, 0);
        drain();

        // ena low blocks commits; release commits 4 edges later
        ena = 1'b0;
        hold(7'h3F, 20);
        check("ena_low_level", level, 0);
        ena = 1'b1;
        sb.push_back(5'h00);
        tick(3);
        check("ena_e3_level", level, 0);
        tick(1);
        check("ena_e4_level", level, 1);
        drain();

        // Overflow: commits 0,1,2,3,4 with no pops
        hold(7'h00, 8);
        sb.push_back(5'h00); hold(7'h3F, 8);
        sb.push_back(5'h01); hold(7'h06, 8);
        sb.push_back(5'h02); hold(7'h5B, 8);
        sb.push_back(5'h03); hold(7'h4F, 8);
        hold(7'h66, 8);
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_digit, 0);
        check("ovf_valid", out_valid, 1);
        drain();
        check("ovf_sticky", overflow, 1);

        // Asynchronous reset mid-count with a non-empty FIFO
        hold(7'h06, 8);
        check("pre_rst_level", level, 1);
        hold(7'h5B, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_level", level, 0);
        check("async_valid", out_valid, 0);
        check("async_overflow", overflow, 0);
        @(posedge clk);
        #1;
        tick(1);
        rst_n = 1'b1;
        sb.push_back(5'h02);
        tick(10);
        check("post_rst_level", level, 1);
        drain();

        // Full FIFO with push and pop on the same edge
        sb.push_back(5'h00); hold(7'h3F, 8);
        sb.push_back(5'h01); hold(7'h06, 8);
        sb.push_back(5'h03); hold(7'h4F, 8);
        sb.push_back(5'h04); hold(7'h66, 8);
        check("fill_level", level, 4);
        sb.push_back(5'h05);
        seg_in = 7'h6D;
        tick(5);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pp_level", level, 4);
        check("pp_overflow", overflow, 0);
        check("pp_head", out_digit, 1);
        drain();

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_seg7_reader.md
# tt_seg7_reader

Receive-side counterpart to the tile's 7-segment output. It samples a 7-segment pattern arriving on input pins, waits until the pattern is stable, and decodes it back to a hex digit. Decoded digits are queued in a small FIFO and handed out over a valid/ready handshake. It sits inside a `tt_um_*` top, taking `seg_in` from `ui_in[6:0]`, so one tile can read another tile's display for loop-back and verification.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronized samples required before a commit; legal range 1..255.
- `FIFO_DEPTH`, default 4: number of entries in the digit queue; must be a power of 2, legal range 2..16.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: when low, no new commits are made; popping the FIFO still works.
- `seg_in` in 7: segments a..g, active-high; bit0 = a, bit6 = g.
- `dp_in` in 1: decimal point; present only with `SEG7_READER_DP_EN`.
- `out_valid` out 1: FIFO is not empty.
- `out_ready` in 1: consumer accepts the head entry.
- `out_digit` out 4: decoded hex value of the head entry.
- `out_err` out 1: head entry came from a pattern not in the decode table.
- `out_dp` out 1: decimal point of the head entry; tied to 0 without the macro.
- `overflow` out 1: sticky flag, set when a commit is dropped because the FIFO is full.
- `level` out 5: current FIFO occupancy.

## Operation
- **Synchronizer:** two flops on `seg_in` (and `dp_in` when enabled) produce `sync`.
- **Stability tracker:**
  - Holds a `cand` register and a counter `cnt`.
  - If `sync != cand`: load `cand`, set `cnt` to 1.
  - Otherwise `cnt` increments and saturates at `STABLE_CYCLES`.
- **Commit:** fires on the cycle `cnt` reaches `STABLE_CYCLES`, provided `ena` is high and `cand != last`.
  - On commit, `last` is updated.
  - If `cand` is blank (all segments off, dp ignored), nothing is pushed. This lets a repeated digit separated by a blank be captured again.
  - Otherwise `cand` is decoded and pushed.
- **Decode table** (seg hex → digit):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - Any other pattern: `out_digit` = 0, `out_err` = 1.
- **`ena` low:** `cnt` is held at 0 and no commits occur. When `ena` returns high, a stable pattern commits `STABLE_CYCLES` cycles later if it differs from `last`.
- **FIFO:** first-word fall-through; head fields drive the outputs directly.
  - Pop when `out_valid && out_ready`.
  - Push while full: if a pop happens in the same cycle, both proceed and `level` stays at `FIFO_DEPTH`. With no pop, the new entry is dropped and `overflow` is set.
  - Pop while empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset values:** all outputs 0, `cand` = 0, `last` = 0 (blank), `cnt` = 0, FIFO empty.

## Timing
- All state updates on `posedge clk`.
- `rst_n` asserts asynchronously at any time, including mid-stability-count or with a full FIFO, and clears all state immediately. Deassertion must be synchronous to `clk`.
- **Latency:** a new pattern held on `seg_in` before edge 1 reaches `sync` after edge 2. It commits on edge 2 + `STABLE_CYCLES`, and `out_valid` is high after that edge when the FIFO was empty. With the default, that is after edge 6.
- A glitch of fewer than `STABLE_CYCLES` synchronized cycles never commits.
- **Pop:** the head advances on the edge where `out_valid && out_ready` is sampled high. The next entry, or `out_valid` = 0, is visible after that edge.
- `level` updates on the same edge as the push or pop.
- `overflow` is set on the edge of the dropped push and is cleared only by reset.

## Configuration
- `SEG7_READER_DP_EN` defined:
  - `dp_in` port exists and is synchronized.
  - dp is part of the `cand`/`last` comparison, so a dp-only change produces a new commit.
  - dp is stored per FIFO entry and driven on `out_dp`.
- Not defined:
  - no `dp_in` port;
  - FIFO entries are 5 bits (digit + err);
  - `out_dp` is constant 0.

## Test plan
- **Reset:** hold `rst_n` = 0 with `seg_in` = 7'h06 → all outputs 0. Release, hold 7'h06 → `out_valid` = 1 after edge 6, `out_digit` = 1, `out_err` = 0, `level` = 1.
- **Glitch and repeat:** 7'h5B for 3 cycles, then 7'h4F stable → only digit 3 is queued. Then hold 7'h4F → no second push. Then blank for 6 cycles, then 7'h4F → a second 3 is queued.
- **Invalid pattern and `ena`:** 7'h7E stable → `out_err` = 1, `out_digit` = 0. With `ena` = 0, 7'h3F stable for 20 cycles → no push.
- **Overflow:** `out_ready` = 0; commit 0,1,2,3,4 → `level` = 4, `overflow` = 1, head = 0. Pop all → 0,1,2,3 in order, then `out_valid` = 0.
- **Full plus simultaneous pop, and reset mid-operation:**
  - Full FIFO, push and pop on the same edge → `level` stays 4, no overflow, new digit becomes the tail.
  - Assert `rst_n` asynchronously mid-count → `level` = 0 immediately.
- **DP (macro on):** 7'h06 with `dp_in` 0 → commit; `dp_in` becomes 1 → second entry with digit 1, `out_dp` = 1.
